nmi_scratch_ram: RTL and testbench
==================================

# nmi_scratch_ram

Native-memory-interface (nmi) responder: a word-organised scratchpad RAM that completes user-core bus requests with byte-strobed writes and a parameterised number of wait states. It sits on the slave side of `nmi_if`, opposite a core adapter such as the user-core wrapper, and serves as local data memory or as a bench target for user-core bring-up.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `DEPTH`, 64: number of 32-bit words; power of two, 2..1024.
- `WAIT_CYCLES`, 0: extra cycles inserted before `ready`; 0..15.
- `clk_i`  input  1  clock; all state changes on rising edge.
- `rst_n_i`  input  1  reset; **one clock; reset is asynchronous and active-low**.
- `nmi`  `nmi_if.slave`  —  `valid`/`addr[31:0]`/`wdata[31:0]`/`wstrb[3:0]` in; `rdata[31:0]`/`ready` out.
- `rd_cnt_o`  output  32  completed reads (only with `NMI_SCRATCH_STAT_EN`).
- `wr_cnt_o`  output  32  completed writes (only with `NMI_SCRATCH_STAT_EN`).

## Operation
- Protocol: master raises `valid` with `addr`/`wdata`/`wstrb` and holds them stable until the cycle `ready`=1; `wstrb`==0 is a read, nonzero is a write; `ready` is a single-cycle pulse and ends the transaction.
- FSM states IDLE, WAIT, RESP.
  - IDLE: `valid`=1 at a clock edge -> latch `addr`, `wdata`, `wstrb`; load wait counter with `WAIT_CYCLES`; next state WAIT if `WAIT_CYCLES`>0, else RESP.
  - WAIT: counter decrements each cycle; when it reaches 1 -> RESP.
  - RESP: `ready`=1; write committed at the end of this cycle; read data presented on `rdata`; -> IDLE unconditionally.
- Address decode: offset = latched `addr` − `BASE_ADDR`; in range iff offset < `DEPTH`*4; word index = offset[log2(DEPTH)+1:2]; `addr[1:0]` ignored.
- Write: for each set `wstrb[i]`, byte i of the word ← `wdata[8i+7:8i]`; unset bytes unchanged.
- Read: `rdata` = full stored word in the RESP cycle; `rdata`=0 in every non-RESP cycle and for writes.
- Out-of-range: write discarded, read returns 32'h0; `ready` still asserted with normal latency (no hang).
- Memory array reset to all zeros.

## Timing
- Reset values: `ready`=0, `rdata`=0, FSM=IDLE, wait counter=0, memory=0, counters=0.
- Latency: `valid` first high in cycle 0 -> `ready`=1 in cycle 1+`WAIT_CYCLES`; exactly one `ready` cycle per transaction.
- `valid` is not sampled during WAIT or RESP; `valid` still high in the cycle after RESP is a new transaction (back-to-back throughput: one transfer per 2+`WAIT_CYCLES` cycles).
- Inputs changing or `valid` dropping during WAIT is a protocol violation: the block completes using latched values; the `ready` pulse is still issued.
- Read-after-write to same word, back-to-back: read returns the newly written data.
- Reset asserted mid-transaction: immediate return to IDLE, `ready`=0, pending write discarded, memory cleared.
- No combinational path from any nmi input to `ready` or `rdata`.

## Configuration
- `NMI_SCRATCH_STAT_EN` defined: `rd_cnt_o`/`wr_cnt_o` present; each increments by 1 in the RESP cycle of a completed read/write (out-of-range included), wrapping 32'hFFFF_FFFF -> 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset then read word 5 (`addr`=BASE+0x14, `wstrb`=0) -> `ready` in cycle 1, `rdata`=32'h0.
- Write 32'hDEAD_BEEF to BASE+0x08 with `wstrb`=4'hF, then `wstrb`=4'b0010 `wdata`=32'h0000_5A00 -> read returns 32'hDEAD_5AEF.
- `WAIT_CYCLES`=3: `valid` held from cycle 0 -> `ready` only in cycle 4, `rdata`=0 in cycles 0-3.
- Read at BASE+`DEPTH`*4 -> `ready` asserted, `rdata`=0; write there -> all in-range words unchanged.
- Back-to-back write/read of BASE+0x00 with `valid` held continuously -> two single-cycle `ready` pulses 2 cycles apart, read returns written value; with `NMI_SCRATCH_STAT_EN`, `rd_cnt_o`=1, `wr_cnt_o`=1.
- Assert `rst_n_i` during WAIT of a write -> `ready` never pulses, subsequent read returns 0.

Source files
------------

// File: rtl/nmi_scratch_ram_if.sv
// Native memory interface bundle: the master drives the request and the slave returns
// read data with a single-cycle ready pulse.
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/nmi_scratch_ram.sv
// Word-organised scratchpad RAM answering nmi requests with byte-strobed writes and
// WAIT_CYCLES wait states. Define NMI_SCRATCH_STAT_EN to add read/write completion counters.
module nmi_scratch_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  nmi_if.slave nmi
`ifdef NMI_SCRATCH_STAT_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
`endif
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH];

  logic [31:0] rd_addr_s;
  logic [3:0]  rd_wstrb_s;
  logic [31:0] rd_off_s;
  logic [31:0] wr_off_s;
  logic        wr_en_s;
  logic [AW-1:0] wr_idx_s;

  // Request capture and wait-state sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (nmi.valid) begin
          addr_d  = nmi.addr;
          wdata_d = nmi.wdata;
          wstrb_d = nmi.wstrb;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Response data is fetched on the edge entering RESP; with no wait states the request
  // is still on the bus at that edge, otherwise the latched copy is used.
  always_comb begin
    rd_addr_s  = (state_q == S_IDLE) ? nmi.addr  : addr_q;
    rd_wstrb_s = (state_q == S_IDLE) ? nmi.wstrb : wstrb_q;
    rd_off_s   = rd_addr_s - BASE_ADDR;
    ready_d    = (state_d == S_RESP);
    if ((state_d == S_RESP) && (rd_wstrb_s == 4'h0) && (rd_off_s < SPAN)) begin
      rdata_d = mem_q[rd_off_s[AW+1:2]];
    end else begin
      rdata_d = 32'h0;
    end
  end

  always_comb begin
    wr_off_s = addr_q - BASE_ADDR;
    wr_idx_s = wr_off_s[AW+1:2];
    wr_en_s  = (state_q == S_RESP) && (wstrb_q != 4'h0) && (wr_off_s < SPAN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; a write commits at the end of its RESP cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem_q[wr_idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign nmi.ready = ready_q;
  assign nmi.rdata = rdata_q;

`ifdef NMI_SCRATCH_STAT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else if (state_q == S_RESP) begin
      if (wstrb_q == 4'h0) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end else begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_nmi_scratch_ram.sv
// Scoreboard bench for nmi_scratch_ram: one instance without wait states, one with three.
module tb_nmi_scratch_ram;
  localparam int W1 = 3;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;
  logic prev0, prev1;

  nmi_if if0();
  nmi_if if1();

`ifdef NMI_SCRATCH_STAT_EN
  logic [31:0] rd0, wr0, rd1, wr1;
`endif

  nmi_scratch_ram #(.BASE_ADDR(32'h0000_0000), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .nmi(if0)
`ifdef NMI_SCRATCH_STAT_EN
    , .rd_cnt_o(rd0), .wr_cnt_o(wr0)
`endif
  );

  nmi_scratch_ram #(.BASE_ADDR(32'h0000_1000), .DEPTH(64), .WAIT_CYCLES(W1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .nmi(if1)
`ifdef NMI_SCRATCH_STAT_EN
    , .rd_cnt_o(rd1), .wr_cnt_o(wr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor for instance 0: pop expected data on every ready, demand zero data otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (if0.ready) begin
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ready0: ready=1 rdata=%h required no response", if0.rdata);
        end else begin
          e0 = q0.pop_front();
          if (if0.rdata !== e0) begin
            n_fail++;
            $display("FAIL rdata0: got %h required %h", if0.rdata, e0);
          end
        end
        n_chk++;
        if (prev0) begin
          n_fail++;
          $display("FAIL pulse0: ready high 2 cycles, required single-cycle pulse");
        end
      end else if (if0.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_rdata0: got %h required 00000000", if0.rdata);
      end
      prev0 = if0.ready;
    end else begin
      prev0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (if1.ready) begin
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ready1: ready=1 rdata=%h required no response", if1.rdata);
        end else begin
          e1 = q1.pop_front();
          if (if1.rdata !== e1) begin
            n_fail++;
            $display("FAIL rdata1: got %h required %h", if1.rdata, e1);
          end
        end
        n_chk++;
        if (prev1) begin
          n_fail++;
          $display("FAIL pulse1: ready high 2 cycles, required single-cycle pulse");
        end
      end else if (if1.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_rdata1: got %h required 00000000", if1.rdata);
      end
      prev1 = if1.ready;
    end else begin
      prev1 = 1'b0;
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if0.ready : if1.ready;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (sel == 0) begin
      if0.valid = v; if0.addr = a; if0.wdata = d; if0.wstrb = s;
    end else begin
      if1.valid = v; if1.addr = a; if1.wdata = d; if1.wstrb = s;
    end
  endtask

  // One transaction; valid stays high on return so a following call is back-to-back.
  task automatic xfer(input int sel, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp, input bit glitch);
    int n;
    int lat;
    lat = (sel == 0) ? 1 : 1 + W1;
    if (sel == 0) q0.push_back(exp);
    else          q1.push_back(exp);
    drive(sel, 1'b1, a, d, s);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      if (glitch && n == 1) begin
        #1;
        drive(sel, 1'b0, a + 32'd4, 32'h0, 4'h0);
      end
      @(negedge clk);
    end while (!rdy(sel) && n < 40);
    n_chk++;
    if (n != lat) begin
      n_fail++;
      $display("FAIL latency%0d: addr=%h ready after %0d cycles required %0d", sel, a, n, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    prev0 = 1'b0;
    prev1 = 1'b0;
    n_chk = 0;
    n_fail = 0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    n_chk++;
    if ({if0.ready, if0.rdata, if1.ready, if1.rdata} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: r0=%b d0=%h r1=%b d1=%h required all 0",
               if0.ready, if0.rdata, if1.ready, if1.rdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    xfer(0, 32'h14, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(0);
    xfer(0, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    idle(0);
    xfer(0, 32'h08, 32'h0000_5A00, 4'b0010, 32'h0, 1'b0);
    idle(0);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'hDEAD_5AEF, 1'b0);
    idle(0);
    xfer(0, 32'h0C, 32'hA5A5_A5A5, 4'b1001, 32'h0, 1'b0);
    idle(0);
    xfer(0, 32'h0E, 32'h0, 4'h0, 32'hA500_00A5, 1'b0);
    idle(0);
    // Out of range: reads zero, write must not alias onto word 0.
    xfer(0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(0);
    xfer(0, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    idle(0);
    xfer(0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'hDEAD_5AEF, 1'b0);
    xfer(0, 32'hFC, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(0);
    // Back-to-back write then read with valid held throughout.
    xfer(0, 32'h00, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h00, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    idle(0);

    xfer(1, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(1);
    xfer(1, 32'h1010, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    xfer(1, 32'h1010, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    idle(1);
    xfer(1, 32'h1014, 32'h1122_3344, 4'hF, 32'h0, 1'b1);
    xfer(1, 32'h1014, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
    xfer(1, 32'h1018, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(1, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(1);

    // Reset during the wait states of a write: no response, write lost, memory cleared.
    drive(1, 1'b1, 32'h1020, 32'h7777_7777, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    n_chk++;
    if (if1.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b required 0", if1.ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    xfer(1, 32'h1020, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(1, 32'h1010, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(1);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(0);
    repeat (3) @(posedge clk);

    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending %0d/%0d required 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
